// File: rtl/d_mem_sized_pkg.sv
// Shared types and helpers for the byte-addressable data memory.
package d_mem_sized_pkg;

  localparam int DMEM_DEPTH_DEFAULT = 1024;
  localparam int WAIT_CNT_W         = 4;

  typedef enum logic [1:0] {
    MSZ_BYTE = 2'd0,
    MSZ_HALF = 2'd1,
    MSZ_WORD = 2'd2,
    MSZ_RSVD = 2'd3
  } msz_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // A request is illegal when its size is reserved or the address is not
  // naturally aligned to that size.
  function automatic logic size_illegal(input msz_e size, input logic [1:0] lo);
    case (size)
      MSZ_BYTE: size_illegal = 1'b0;
      MSZ_HALF: size_illegal = lo[0];
      MSZ_WORD: size_illegal = (lo != 2'b00);
      default:  size_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/d_mem_sized_lane.sv
// Combinational byte-lane steering: byte enables, aligned store data,
// extended load value and alignment check for one access.
module d_mem_sized_lane
  import d_mem_sized_pkg::*;
(
  input  msz_e        size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wlane_o,
  output logic [31:0] rdata_o,
  output logic        illegal_o
);

  logic [31:0] shifted;

  assign illegal_o = size_illegal(size_i, addr_lo_i);
  assign shifted   = rdword_i >> {addr_lo_i, 3'b000};

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    be_o    = 4'b0000;
    wlane_o = 32'd0;
    rdata_o = 32'd0;
    case (size_i)
      MSZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wlane_o = {4{wdata_i[7:0]}};
        rdata_o = uns_i ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      MSZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wlane_o = {2{wdata_i[15:0]}};
        rdata_o = uns_i ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      MSZ_WORD: begin
        be_o    = 4'b1111;
        wlane_o = wdata_i;
        rdata_o = rdword_i;
      end
      default: ;
    endcase
    if (illegal_o) be_o = 4'b0000;
  end

endmodule

// File: rtl/d_mem_sized.sv
// Byte-addressable data memory with sized loads/stores, programmable wait
// states, Ready/ReadValid handshake and misalignment reporting.
module d_mem_sized
  import d_mem_sized_pkg::*;
#(
  parameter int DEPTH_WORDS = DMEM_DEPTH_DEFAULT,
  parameter int WAIT_STATES = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        ReadValid,
  output logic        Ready,
  output logic        Misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  logic [AW-1:0] req_idx_q,   req_idx_d;
  logic [1:0]    req_lo_q,    req_lo_d;
  msz_e          req_size_q,  req_size_d;
  logic          req_uns_q,   req_uns_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic          req_rd_q,    req_rd_d;
  logic          req_wr_q,    req_wr_d;

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        mis_q, mis_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] cur_idx;
  logic [1:0]    cur_lo;
  msz_e          cur_size;
  logic          cur_uns, cur_rd, cur_wr;
  logic [31:0]   cur_wdata, rdword;
  logic [3:0]    be;
  logic [31:0]   wlane, lane_rdata;
  logic          illegal, accept, access;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^address[31:AW+2];

  // In IDLE the live request is steered straight to the array so a zero-wait
  // access completes at the accepting edge; in WAIT the latched copy is used.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_idx   = address[AW+1:2];
      cur_lo    = address[1:0];
      cur_size  = msz_e'(MemSize);
      cur_uns   = MemUnsigned;
      cur_wdata = WriteData;
      cur_wr    = MemWrite;
      cur_rd    = MemRead & ~MemWrite;
    end else begin
      cur_idx   = req_idx_q;
      cur_lo    = req_lo_q;
      cur_size  = req_size_q;
      cur_uns   = req_uns_q;
      cur_wdata = req_wdata_q;
      cur_wr    = req_wr_q;
      cur_rd    = req_rd_q;
    end
  end

  assign rdword = mem_q[cur_idx];
  assign accept = (state_q == ST_IDLE) && (MemRead || MemWrite);

  d_mem_sized_lane u_lane (
    .size_i    (cur_size),
    .addr_lo_i (cur_lo),
    .uns_i     (cur_uns),
    .wdata_i   (cur_wdata),
    .rdword_i  (rdword),
    .be_o      (be),
    .wlane_o   (wlane),
    .rdata_o   (lane_rdata),
    .illegal_o (illegal)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_idx_d   = req_idx_q;
    req_lo_d    = req_lo_q;
    req_size_d  = req_size_q;
    req_uns_d   = req_uns_q;
    req_wdata_d = req_wdata_q;
    req_rd_d    = req_rd_q;
    req_wr_d    = req_wr_q;
    access      = 1'b0;
    mis_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_idx_d   = cur_idx;
          req_lo_d    = cur_lo;
          req_size_d  = cur_size;
          req_uns_d   = cur_uns;
          req_wdata_d = cur_wdata;
          req_rd_d    = cur_rd;
          req_wr_d    = cur_wr;
          if (illegal) begin
            mis_d = 1'b1;
          end else if (WAIT_STATES == 0) begin
            access = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= WAIT_CNT_W'(1)) begin
          access  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (access && cur_rd) begin
      rdata_d  = lane_rdata;
      rvalid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rdata_q     <= 32'd0;
      rvalid_q    <= 1'b0;
      mis_q       <= 1'b0;
      req_idx_q   <= '0;
      req_lo_q    <= 2'b00;
      req_size_q  <= MSZ_BYTE;
      req_uns_q   <= 1'b0;
      req_wdata_q <= 32'd0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      mis_q       <= mis_d;
      req_idx_q   <= req_idx_d;
      req_lo_q    <= req_lo_d;
      req_size_q  <= req_size_d;
      req_uns_q   <= req_uns_d;
      req_wdata_q <= req_wdata_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
    end
  end

  // NOTE: the storage array has no reset; reset only blocks a pending write.
  always_ff @(posedge clock) begin
    if (access && cur_wr && !reset) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[cur_idx][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
  end

  assign ReadData   = rdata_q;
  assign ReadValid  = rvalid_q;
  assign Misaligned = mis_q;
  assign Ready      = (state_q == ST_IDLE) && !reset;

endmodule

// File: tb/tb_d_mem_sized.sv
// Directed self-checking bench: a zero-wait instance for lane/extension and
// alignment behaviour, and a three-wait instance for handshake and reset.
module tb_d_mem_sized;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        rd0 = 0, wr0 = 0, un0 = 0;
  logic [1:0]  sz0 = 0;
  logic [31:0] ad0 = 0, wd0 = 0;
  logic [31:0] q0;
  logic        rv0, rdy0, mis0;

  logic        rd3 = 0, wr3 = 0, un3 = 0;
  logic [1:0]  sz3 = 0;
  logic [31:0] ad3 = 0, wd3 = 0;
  logic [31:0] q3;
  logic        rv3, rdy3, mis3;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  d_mem_sized #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clock(clock), .reset(reset), .MemRead(rd0), .MemWrite(wr0), .MemSize(sz0),
    .MemUnsigned(un0), .address(ad0), .WriteData(wd0), .ReadData(q0),
    .ReadValid(rv0), .Ready(rdy0), .Misaligned(mis0)
  );

  d_mem_sized #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_dut3 (
    .clock(clock), .reset(reset), .MemRead(rd3), .MemWrite(wr3), .MemSize(sz3),
    .MemUnsigned(un3), .address(ad3), .WriteData(wd3), .ReadData(q3),
    .ReadValid(rv3), .Ready(rdy3), .Misaligned(mis3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drv0(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic un, input logic [31:0] a, input logic [31:0] d);
    rd0 = rd; wr0 = wr; sz0 = sz; un0 = un; ad0 = a; wd0 = d;
  endtask

  task automatic drv3(input logic rd, input logic wr, input logic [1:0] sz,
                      input logic un, input logic [31:0] a, input logic [31:0] d);
    rd3 = rd; wr3 = wr; sz3 = sz; un3 = un; ad3 = a; wd3 = d;
  endtask

  initial begin
    tick(); tick();
    check("rst_rdata0", q0, 32'h0);
    check("rst_rvalid0", {31'd0, rv0}, 32'd0);
    check("rst_mis0", {31'd0, mis0}, 32'd0);
    check("rst_ready0", {31'd0, rdy0}, 32'd0);
    check("rst_ready3", {31'd0, rdy3}, 32'd0);
    reset = 1'b0;
    #1;
    check("ready0_after_rst", {31'd0, rdy0}, 32'd1);

    // Zero-wait instance: stores, sized loads, back-to-back every cycle
    drv0(0, 1, 2, 0, 32'h10, 32'h11223344); tick();
    check("sw_rv", {31'd0, rv0}, 32'd0);
    check("sw_ready", {31'd0, rdy0}, 32'd1);
    drv0(1, 0, 2, 0, 32'h10, 0); tick();
    check("lw1_rv", {31'd0, rv0}, 32'd1);
    check("lw1_data", q0, 32'h11223344);
    drv0(0, 0, 0, 0, 0, 0); tick();
    check("lw1_rv_pulse", {31'd0, rv0}, 32'd0);
    check("lw1_hold", q0, 32'h11223344);

    drv0(0, 1, 0, 0, 32'h11, 32'h123456AA); tick();
    drv0(1, 0, 2, 0, 32'h10, 0); tick();
    check("sb_lw", q0, 32'h1122AA44);
    drv0(1, 0, 0, 0, 32'h11, 0); tick();
    check("lb", q0, 32'hFFFFFFAA);
    drv0(1, 0, 0, 1, 32'h11, 0); tick();
    check("lbu", q0, 32'h000000AA);

    drv0(0, 1, 1, 0, 32'h12, 32'hFFFF8001); tick();
    drv0(1, 0, 1, 0, 32'h12, 0); tick();
    check("lh", q0, 32'hFFFF8001);
    drv0(1, 0, 1, 1, 32'h12, 0); tick();
    check("lhu", q0, 32'h00008001);
    drv0(1, 0, 2, 1, 32'h10, 0); tick();
    check("sh_lw_unsigned_ignored", q0, 32'h8001AA44);

    // Illegal requests: pulse Misaligned, no load, no store
    drv0(1, 0, 1, 0, 32'h13, 0); tick();
    check("lh13_mis", {31'd0, mis0}, 32'd1);
    check("lh13_rv", {31'd0, rv0}, 32'd0);
    check("lh13_hold", q0, 32'h8001AA44);
    drv0(0, 1, 2, 0, 32'h12, 32'hDEADBEEF); tick();
    check("sw12_mis", {31'd0, mis0}, 32'd1);
    drv0(1, 0, 3, 0, 32'h10, 0); tick();
    check("sz3_mis", {31'd0, mis0}, 32'd1);
    check("sz3_rv", {31'd0, rv0}, 32'd0);
    drv0(1, 0, 2, 0, 32'h10, 0); tick();
    check("after_illegal_mis", {31'd0, mis0}, 32'd0);
    check("after_illegal_word", q0, 32'h8001AA44);

    // Read and write together act as a store only
    drv0(1, 1, 0, 0, 32'h10, 32'h00000055); tick();
    check("rdwr_rv", {31'd0, rv0}, 32'd0);
    drv0(1, 0, 0, 0, 32'h13, 0); tick();
    check("lb13_signed", q0, 32'hFFFFFF80);
    drv0(1, 0, 2, 0, 32'h1010, 0); tick();
    check("wrap0", q0, 32'h8001AA55);
    drv0(0, 0, 0, 0, 0, 0);

    // Three-wait instance: busy window and ignored requests
    drv3(0, 1, 2, 0, 32'h10, 32'hCAFEF00D); tick();
    check("ws_sw_t1_ready", {31'd0, rdy3}, 32'd0);
    drv3(1, 0, 2, 0, 32'h20, 0); tick();
    check("ws_sw_t2_ready", {31'd0, rdy3}, 32'd0);
    tick();
    check("ws_sw_t3_ready", {31'd0, rdy3}, 32'd0);
    check("ws_sw_rv", {31'd0, rv3}, 32'd0);
    drv3(0, 0, 0, 0, 0, 0); tick();
    check("ws_sw_t4_ready", {31'd0, rdy3}, 32'd1);
    check("ws_busy_ignored_rv", {31'd0, rv3}, 32'd0);

    drv3(1, 0, 2, 0, 32'h10, 0); tick();
    check("ws_lw_t1_ready", {31'd0, rdy3}, 32'd0);
    drv3(0, 1, 2, 0, 32'h10, 32'h0); tick();
    check("ws_lw_t2_ready", {31'd0, rdy3}, 32'd0);
    check("ws_lw_t2_rv", {31'd0, rv3}, 32'd0);
    tick();
    check("ws_lw_t3_ready", {31'd0, rdy3}, 32'd0);
    check("ws_lw_t3_rv", {31'd0, rv3}, 32'd0);
    drv3(0, 0, 0, 0, 0, 0); tick();
    check("ws_lw_t4_rv", {31'd0, rv3}, 32'd1);
    check("ws_lw_t4_data", q3, 32'hCAFEF00D);
    check("ws_lw_t4_ready", {31'd0, rdy3}, 32'd1);
    tick();
    check("ws_lw_t5_rv", {31'd0, rv3}, 32'd0);

    // Reset during WAIT discards the pending store
    drv3(0, 1, 2, 0, 32'h10, 32'h99999999); tick();
    drv3(0, 0, 0, 0, 0, 0);
    check("rst_wait_t1_ready", {31'd0, rdy3}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_wait_t3_ready", {31'd0, rdy3}, 32'd1);
    check("rst_wait_rdata", q3, 32'h0);
    check("rst_wait_rv", {31'd0, rv3}, 32'd0);
    check("rst_wait_mis", {31'd0, mis3}, 32'd0);

    drv3(1, 0, 2, 0, 32'h1010, 0); tick();
    drv3(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();
    check("ws_wrap_rv", {31'd0, rv3}, 32'd1);
    check("ws_wrap_unchanged", q3, 32'hCAFEF00D);

    // Illegal access skips the wait states
    drv3(1, 0, 2, 0, 32'h11, 0); tick();
    drv3(0, 0, 0, 0, 0, 0);
    check("ws_mis", {31'd0, mis3}, 32'd1);
    check("ws_mis_ready", {31'd0, rdy3}, 32'd1);
    check("ws_mis_rv", {31'd0, rv3}, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
